// File: rtl/regfile_wb_port.sv
// rtl/regfile_wb_port.sv - integer register file with write-back bypass and commit counter
module regfile_wb_port #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteW,
    input  logic [4:0]       RdW,
    input  logic [XLEN-1:0]  ResultW,
    input  logic [4:0]       A1D,
    input  logic [4:0]       A2D,
    output logic [XLEN-1:0]  RD1D,
    output logic [XLEN-1:0]  RD2D,
    output logic [CNT_W-1:0] WbCount,
    output logic             WbCommitW
);

    // x0 has no storage; entries 1..31 only
    logic [XLEN-1:0]  r_regs [1:31];
    logic [CNT_W-1:0] r_count;
    logic             w_commit;
    logic [XLEN-1:0]  w_rd1;
    logic [XLEN-1:0]  w_rd2;

    // Writes to x0 and writes during reset never commit
    assign w_commit = RegWriteW & (RdW != 5'd0) & ~reset;

    // Architectural state update; reset clears everything and drops a concurrent write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[RdW] <= ResultW;
        end
    end

    // Committed-write counter, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_commit && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Read port 1: write-first bypass so D sees the value retiring in W this cycle
    always_comb begin
        w_rd1 = '0;
        if (!reset && (A1D != 5'd0)) begin
            if (w_commit && (RdW == A1D)) begin
                w_rd1 = ResultW;
            end else begin
                w_rd1 = r_regs[A1D];
            end
        end
    end

    // Read port 2: same rule as port 1
    always_comb begin
        w_rd2 = '0;
        if (!reset && (A2D != 5'd0)) begin
            if (w_commit && (RdW == A2D)) begin
                w_rd2 = ResultW;
            end else begin
                w_rd2 = r_regs[A2D];
            end
        end
    end

    assign RD1D      = w_rd1;
    assign RD2D      = w_rd2;
    assign WbCount   = r_count;
    assign WbCommitW = w_commit;

endmodule

// File: tb/tb_regfile_wb_port.sv
// tb/tb_regfile_wb_port.sv - directed self-checking bench for regfile_wb_port
module tb_regfile_wb_port;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;

    logic [31:0] RD1D, RD2D;
    logic [31:0] WbCount;
    logic        WbCommitW;

    logic [31:0] s_RD1D, s_RD2D;
    logic [2:0]  s_WbCount;
    logic        s_WbCommitW;

    int checks;
    int errors;

    regfile_wb_port #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D), .WbCount(WbCount), .WbCommitW(WbCommitW)
    );

    regfile_wb_port #(.XLEN(32), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .A1D(A1D), .A2D(A2D), .RD1D(s_RD1D), .RD2D(s_RD2D), .WbCount(s_WbCount), .WbCommitW(s_WbCommitW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0; A1D = 5'd5; A2D = 5'd31;
        step();
        step();
        #1;
        checks++; if (RD1D !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h want %h", RD1D, 32'h0); end
        checks++; if (RD2D !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h want %h", RD2D, 32'h0); end
        checks++; if (WbCount !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", WbCount); end
        RegWriteW = 1'b1; RdW = 5'd4; ResultW = 32'h1;
        #1;
        checks++; if (WbCommitW !== 1'b0) begin errors++; $display("FAIL reset_commit got %b want 0", WbCommitW); end
        step();
        reset = 1'b0; RegWriteW = 1'b0; A1D = 5'd4;
        #1;
        checks++; if (RD1D !== 32'h0) begin errors++; $display("FAIL reset_dropwrite got %h want %h", RD1D, 32'h0); end
        checks++; if (WbCount !== 32'h0) begin errors++; $display("FAIL reset_count_after got %0d want 0", WbCount); end
    endtask

    task automatic test_write();
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF; A1D = 5'd0; A2D = 5'd0;
        #1;
        checks++; if (WbCommitW !== 1'b1) begin errors++; $display("FAIL write_commit got %b want 1", WbCommitW); end
        step();
        RegWriteW = 1'b0; A1D = 5'd3;
        #1;
        checks++; if (RD1D !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rd1 got %h want %h", RD1D, 32'hDEADBEEF); end
        checks++; if (WbCount !== 32'd1) begin errors++; $display("FAIL write_count got %0d want 1", WbCount); end
    endtask

    task automatic test_bypass();
        RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h12345678; A1D = 5'd7; A2D = 5'd7;
        #1;
        checks++; if (RD1D !== 32'h12345678) begin errors++; $display("FAIL bypass_rd1 got %h want %h", RD1D, 32'h12345678); end
        checks++; if (RD2D !== 32'h12345678) begin errors++; $display("FAIL bypass_rd2 got %h want %h", RD2D, 32'h12345678); end
        checks++; if (WbCommitW !== 1'b1) begin errors++; $display("FAIL bypass_commit got %b want 1", WbCommitW); end
        step();
        RegWriteW = 1'b0; A2D = 5'd3;
        #1;
        checks++; if (RD1D !== 32'h12345678) begin errors++; $display("FAIL bypass_stored got %h want %h", RD1D, 32'h12345678); end
        checks++; if (RD2D !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other got %h want %h", RD2D, 32'hDEADBEEF); end
        checks++; if (WbCount !== 32'd2) begin errors++; $display("FAIL bypass_count got %0d want 2", WbCount); end
        // write to a different index must not disturb reads of r7
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hCAFEF00D; A1D = 5'd7; A2D = 5'd5;
        #1;
        checks++; if (RD1D !== 32'h12345678) begin errors++; $display("FAIL nobypass_rd1 got %h want %h", RD1D, 32'h12345678); end
        checks++; if (RD2D !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_port2 got %h want %h", RD2D, 32'hCAFEF00D); end
        step();
        RegWriteW = 1'b0;
    endtask

    task automatic test_x0();
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFFFFFF; A1D = 5'd0; A2D = 5'd3;
        #1;
        checks++; if (RD1D !== 32'h0) begin errors++; $display("FAIL x0_rd1 got %h want %h", RD1D, 32'h0); end
        checks++; if (WbCommitW !== 1'b0) begin errors++; $display("FAIL x0_commit got %b want 0", WbCommitW); end
        checks++; if (RD2D !== 32'hDEADBEEF) begin errors++; $display("FAIL x0_rd2 got %h want %h", RD2D, 32'hDEADBEEF); end
        step();
        RegWriteW = 1'b0;
        #1;
        checks++; if (RD1D !== 32'h0) begin errors++; $display("FAIL x0_after got %h want %h", RD1D, 32'h0); end
        checks++; if (WbCount !== 32'd3) begin errors++; $display("FAIL x0_count got %0d want 3", WbCount); end
    endtask

    task automatic test_reset_collision();
        RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h55; A1D = 5'd9;
        step();
        RegWriteW = 1'b0;
        #1;
        checks++; if (RD1D !== 32'h55) begin errors++; $display("FAIL coll_pre got %h want %h", RD1D, 32'h55); end
        reset = 1'b1; RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'hAA; A1D = 5'd9; A2D = 5'd3;
        #1;
        checks++; if (RD1D !== 32'h0) begin errors++; $display("FAIL coll_during got %h want %h", RD1D, 32'h0); end
        checks++; if (WbCommitW !== 1'b0) begin errors++; $display("FAIL coll_commit got %b want 0", WbCommitW); end
        step();
        reset = 1'b0; RegWriteW = 1'b0;
        #1;
        checks++; if (RD1D !== 32'h0) begin errors++; $display("FAIL coll_after got %h want %h", RD1D, 32'h0); end
        checks++; if (RD2D !== 32'h0) begin errors++; $display("FAIL coll_cleared got %h want %h", RD2D, 32'h0); end
        checks++; if (WbCount !== 32'd0) begin errors++; $display("FAIL coll_count got %0d want 0", WbCount); end
    endtask

    task automatic test_saturation();
        logic [31:0] v;
        for (int k = 1; k <= 10; k++) begin
            RegWriteW = 1'b1; RdW = 5'(k); ResultW = 32'h11111111 * k;
            step();
            RegWriteW = 1'b0;
            #1;
            checks++; if (s_WbCount !== 3'((k > 7) ? 7 : k)) begin errors++; $display("FAIL sat_count%0d got %0d want %0d", k, s_WbCount, (k > 7) ? 7 : k); end
            checks++; if (WbCount !== 32'(k)) begin errors++; $display("FAIL wide_count%0d got %0d want %0d", k, WbCount, k); end
        end
        for (int k = 1; k <= 10; k++) begin
            A1D = 5'(k); A2D = 5'(11 - k);
            v = 32'h11111111 * k;
            #1;
            checks++; if (s_RD1D !== v) begin errors++; $display("FAIL sat_reg%0d got %h want %h", k, s_RD1D, v); end
            v = 32'h11111111 * (11 - k);
            checks++; if (RD2D !== v) begin errors++; $display("FAIL wide_reg%0d got %h want %h", 11 - k, RD2D, v); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write();
        test_bypass();
        test_x0();
        test_reset_collision();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
